// File: rtl/uat_fsm.sv
// Framed serial transmitter: start bit, LSB-first payload, stop bit, then an enforced idle gap; sig_out lags accept by one cycle.
// Backpressure: ready is high only in IDLE, and send_in is dropped otherwise; UAT_FRAME_CNT_EN adds a completed-frame counter output.
module uat_fsm #(
    parameter int CLK_PER_BIT = 10416,
    parameter int PKT_LNGTH   = 162,
    parameter int GAP_CYCLES  = 2_100_000
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [PKT_LNGTH-1:0] data_in,
    input  logic                 send_in,
    output logic                 ready,
`ifdef UAT_FRAME_CNT_EN
    output logic [15:0]          frame_cnt,
`endif
    output logic                 sig_out
);
    localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int IW = $clog2(PKT_LNGTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLK_PER_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PKT_LNGTH - 1);

    typedef enum logic [2:0] {
        S_GAP   = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [PKT_LNGTH-1:0]   sh_q, sh_d;
    logic                   sig_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_GAP;
            bit_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            sig_out <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            sig_out <= sig_d;
        end
    end

    // sig_d is the line level for the cycle after this edge, so every transition also picks the next level.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        sig_d   = 1'b1;
        ready   = 1'b0;
        case (state_q)
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            S_IDLE: begin
                ready = 1'b1;
                if (send_in) begin
                    sh_d    = data_in;
                    bit_d   = '0;
                    state_d = S_START;
                    sig_d   = 1'b0;
                end
            end
            S_START: begin
                sig_d = 1'b0;
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                    sig_d   = sh_q[0];
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            S_DATA: begin
                sig_d = sh_q[0];
                if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                        sig_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        sh_d  = sh_q >> 1;
                        sig_d = sh_d[0];
                    end
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            S_STOP: begin
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    state_d = S_GAP;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: begin
                state_d = S_GAP;
                bit_d   = '0;
                gap_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

`ifdef UAT_FRAME_CNT_EN
    logic frame_done;
    assign frame_done = (state_q == S_STOP) && (bit_q == BIT_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)         frame_cnt <= '0;
        else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_uat_fsm.sv
// Bench for uat_fsm: a frame-level model queues expected per-cycle (ready, line, frame count); a monitor compares at negedge.
module tb_uat_fsm;
    localparam int CPB = 4;
    localparam int PKT = 8;
    localparam int GAP = 10;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           send_in;
    logic [PKT-1:0] data_in;
    logic           ready;
    logic           sig_out;
`ifdef UAT_FRAME_CNT_EN
    logic [15:0]    frame_cnt;
`endif

    uat_fsm #(.CLK_PER_BIT(CPB), .PKT_LNGTH(PKT), .GAP_CYCLES(GAP)) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .data_in (data_in),
        .send_in (send_in),
        .ready   (ready),
`ifdef UAT_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .sig_out (sig_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        rdy;
        logic        sig;
        logic [15:0] fc;
    } samp_t;

    samp_t       pend[$];
    samp_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        in_reset;
    logic [15:0] model_fc;

    function automatic samp_t mk(input logic r, input logic s);
        samp_t x;
        x.rdy = r;
        x.sig = s;
        x.fc  = model_fc;
        return x;
    endfunction

    // Whole frame as a waveform: start, LSB-first data, stop, then the mandatory gap.
    task automatic push_frame(input logic [PKT-1:0] d);
        for (int i = 0; i < CPB; i++) pend.push_back(mk(1'b0, 1'b0));
        for (int b = 0; b < PKT; b++)
            for (int i = 0; i < CPB; i++) pend.push_back(mk(1'b0, d[b]));
        for (int i = 0; i < CPB; i++) pend.push_back(mk(1'b0, 1'b1));
        model_fc = model_fc + 16'd1;
        for (int i = 0; i < GAP; i++) pend.push_back(mk(1'b0, 1'b1));
    endtask

    task automatic step(input logic rst, input logic snd, input logic [PKT-1:0] d,
                        output logic acc);
        samp_t e;
        @(posedge clk_in);
        #1;
        cyc++;
        acc = 1'b0;
        if (!rst) begin
            rst_in   = 1'b0;
            in_reset = 1'b1;
            pend.delete();
            model_fc = 16'd0;
            e = mk(1'b0, 1'b1);
        end else begin
            if (in_reset) begin
                rst_in   = 1'b1;
                in_reset = 1'b0;
                for (int i = 0; i < GAP; i++) pend.push_back(mk(1'b0, 1'b1));
            end
            if (pend.size() > 0) e = pend.pop_front();
            else                 e = mk(1'b1, 1'b1);
        end
        sb.push_back(e);
        send_in = snd;
        data_in = d;
        if (rst && e.rdy && snd) begin
            push_frame(d);
            acc = 1'b1;
        end
    endtask

    initial begin : monitor
        samp_t e;
        logic  ok;
        forever begin
            @(negedge clk_in);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty cycle %0d: no expected sample queued", cyc);
            end else begin
                e  = sb.pop_front();
                ok = (ready === e.rdy) && (sig_out === e.sig);
`ifdef UAT_FRAME_CNT_EN
                ok = ok && (frame_cnt === e.fc);
                if (!ok) begin
                    n_fail++;
                    $display("FAIL line cycle %0d: got ready=%b sig=%b cnt=%h, want ready=%b sig=%b cnt=%h",
                             cyc, ready, sig_out, frame_cnt, e.rdy, e.sig, e.fc);
                end
`else
                if (!ok) begin
                    n_fail++;
                    $display("FAIL line cycle %0d: got ready=%b sig=%b, want ready=%b sig=%b",
                             cyc, ready, sig_out, e.rdy, e.sig);
                end
`endif
            end
        end
    end

    initial begin : stim
        logic acc;
        rst_in   = 1'b0;
        send_in  = 1'b0;
        data_in  = '0;
        in_reset = 1'b1;
        model_fc = 16'd0;

        repeat (3) step(1'b0, 1'b1, PKT'($urandom), acc);
        repeat (20) step(1'b1, 1'b0, PKT'($urandom), acc);

`ifdef UAT_FRAME_CNT_EN
        @(negedge clk_in);
        #1;
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        model_fc = 16'hFFFF;
`endif

        step(1'b1, 1'b1, 8'hA5, acc);
        repeat (60) step(1'b1, 1'b0, PKT'($urandom), acc);

        // Held request: 8'h00 then 8'hFF at accept time, noise on data_in mid-frame.
        step(1'b1, 1'b1, 8'h00, acc);
        repeat (120) step(1'b1, 1'b1, (pend.size() == 0) ? 8'hFF : PKT'($urandom), acc);
        repeat (60) step(1'b1, 1'b0, PKT'($urandom), acc);

        // Reset lands in the middle of data bit 3.
        step(1'b1, 1'b1, 8'h00, acc);
        repeat (18) step(1'b1, 1'b0, PKT'($urandom), acc);
        repeat (3) step(1'b0, 1'b0, PKT'($urandom), acc);
        repeat (30) step(1'b1, 1'b0, PKT'($urandom), acc);

        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 249) != 0), ($urandom_range(0, 3) == 0), PKT'($urandom), acc);

        @(negedge clk_in);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uat_fsm.md
UAT_FSM -- requirements
Module: uat_fsm

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 10416, meaning clk_in cycles per serial bit (100 MHz / 9600 baud, 16 x 651).
REQ-002 SHALL have parameter PKT_LNGTH, default 162, meaning payload bits per frame.
REQ-003 SHALL have parameter GAP_CYCLES, default 2_100_000, meaning the minimum line-high idle before each start bit (must exceed the receiver's 2_000_000-cycle arm time).
REQ-004 SHALL have port clk_in, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port data_in, input, PKT_LNGTH bits: payload, captured on accept.
REQ-007 SHALL have port send_in, input, 1 bit: request to transmit data_in.
REQ-008 SHALL have port ready, output, 1 bit: high when a request will be accepted this cycle.
REQ-009 SHALL have port sig_out, output, 1 bit: serial line, idle high, registered.

Function
REQ-010 SHALL implement states GAP, IDLE, START, DATA, STOP.
REQ-011 GAP: sig_out=1; count GAP_CYCLES cycles, then go to IDLE.
REQ-012 IDLE: ready=1, sig_out=1; on send_in=1, load data_in into the shift register and go to START on the next edge (accept = send_in && ready).
REQ-013 ready SHALL be 1 only in IDLE and SHALL be combinational from state.
REQ-014 START: sig_out=0 for exactly CLK_PER_BIT cycles, beginning the cycle after accept.
REQ-015 DATA: output PKT_LNGTH bits, LSB (data_in[0]) first, each held exactly CLK_PER_BIT cycles, with no gaps.
REQ-016 STOP: sig_out=1 for CLK_PER_BIT cycles, then go to GAP; total frame = (PKT_LNGTH+2)*CLK_PER_BIT cycles.
REQ-017 send_in outside IDLE SHALL be ignored, not queued; data_in changes after accept SHALL not affect the frame.
REQ-018 send_in held high continuously SHALL yield back-to-back frames separated by exactly GAP_CYCLES+1 high cycles after STOP (GAP plus the IDLE accept cycle).
REQ-019 The bit-period counter SHALL be ceil(log2(CLK_PER_BIT)) wide; the gap counter SHALL be ceil(log2(GAP_CYCLES+1)) wide; the bit index SHALL be ceil(log2(PKT_LNGTH+1)) wide. No counter SHALL wrap within a state.
REQ-020 An illegal state encoding SHALL recover to GAP on the next edge, with sig_out=1.

Reset
REQ-021 rst_in=0 SHALL immediately, without a clock edge, force state=GAP, sig_out=1, ready=0, all counters=0, and shift register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; after release, a full GAP_CYCLES of high line SHALL precede any start bit.
REQ-023 Release of rst_in SHALL be taken synchronously to clk_in; the first counted gap cycle is the first edge after release.

Configuration
REQ-024 Macro UAT_FRAME_CNT_EN defined: add output frame_cnt[15:0], reset to 0, incremented on the last STOP cycle of each completed frame, wrapping 0xFFFF to 0x0000; aborted frames are not counted.
REQ-025 Macro UAT_FRAME_CNT_EN undefined: the frame_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification (CLK_PER_BIT=4, GAP_CYCLES=10, PKT_LNGTH=8 unless noted)
REQ-026 Release reset, hold send_in=0 -> sig_out=1 throughout; ready rises exactly 10 cycles after release.
REQ-027 One-cycle pulse of send_in with data_in=8'hA5 in IDLE -> sig_out: 4 cycles 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles 1; ready=0 for 40+10 cycles.
REQ-028 send_in held high with 8'h00 then 8'hFF -> two frames; the second start bit falls exactly 11 cycles after the first stop bit ends; data_in changes mid-frame are ignored.
REQ-029 rst_in=0 during bit 3 of a frame -> sig_out=1 in the same cycle; after release, no start bit for 10 cycles; with UAT_FRAME_CNT_EN, frame_cnt=0.
REQ-030 Defaults (10416/162/2_100_000), looped into the existing 162-bit receiver with random payload -> receiver data_out equals the sent payload, and ready matches.
REQ-031 UAT_FRAME_CNT_EN with frame_cnt preset to 0xFFFF (by forcing it in the bench) and one frame -> frame_cnt=0x0000.
